// File: rtl/canonical_code_gen.sv
// canonical_code_gen
//   Builds canonical Huffman codes from a per-symbol stream of code lengths.
//   A frame is captured into a length table while a per-length histogram is
//   kept. Next_code per length is then built over MAX_LEN cycles. Finally one
//   {symbol, length, code} is emitted per symbol, in symbol order, over
//   valid/ready.
// Ports
//   clk, rst        clock (rising edge), async active-low reset
//   symbol_i        {num[DW+1], freq[FW], len[DW+1]}; freq is not used
//   input_start_i   first symbol of a frame (accepted only when idle)
//   input_end_i     last symbol of a frame
//   busy_o          frame in progress
//   code_valid_o    code_* outputs valid; code_ready_i accepts them
//   code_sym_o      symbol index
//   code_len_o      code length, 0 = unused symbol
//   code_o          right-justified code
//   code_last_o     marks the last symbol of the frame
//   err_o           sticky length-overflow / oversubscription flag
module canonical_code_gen #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FREQ_WIDTH = 8,
   parameter int unsigned MAX_LEN    = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [2*(DATA_WIDTH+1)+FREQ_WIDTH-1:0]   symbol_i,
   input  logic                                     input_start_i,
   input  logic                                     input_end_i,
   output logic                                     busy_o,
   output logic                                     code_valid_o,
   input  logic                                     code_ready_i,
   output logic [DATA_WIDTH-1:0]                    code_sym_o,
   output logic [$clog2(MAX_LEN+1)-1:0]             code_len_o,
   output logic [MAX_LEN-1:0]                       code_o,
   output logic                                     code_last_o,
   output logic                                     err_o
);

   localparam int unsigned DATA_SIZE = 1 << DATA_WIDTH;
   localparam int unsigned LW        = $clog2(MAX_LEN + 1);
   localparam int unsigned RLW       = DATA_WIDTH + 1;
   localparam int unsigned SYMW      = 2 * RLW + FREQ_WIDTH;
   localparam int unsigned CW        = DATA_WIDTH + 1;
   localparam int unsigned NW        = MAX_LEN + 1;
   localparam int unsigned SW        = ((NW > CW) ? NW : CW) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_NEXTCODE, S_ASSIGN} state_t;

   state_t               r_state, w_state_nxt;
   logic [LW-1:0]        r_len [DATA_SIZE];
   logic [DATA_SIZE-1:0] r_vld;
   logic [CW-1:0]        r_bl  [MAX_LEN+1];
   logic [NW-1:0]        r_nc  [MAX_LEN+1];
   logic [NW-1:0]        r_code_acc;
   logic [LW-1:0]        r_l;
   logic                 r_busy, r_code_valid, r_code_last, r_err;
   logic [DATA_WIDTH-1:0] r_code_sym;
   logic [LW-1:0]        r_code_len;
   logic [MAX_LEN-1:0]   r_code;

   logic                  w_cap_first, w_cap, w_nc_step, w_hs, w_ld_first, w_ld_next;
   logic [RLW-1:0]        w_num, w_rlen;
   logic [DATA_WIDTH-1:0] w_idx, w_ld_sym;
   logic                  w_ovf, w_kraft, w_ld_bump, w_unused;
   logic [LW-1:0]         w_new_len, w_old_len, w_ld_len;
   logic [CW-1:0]         w_bl_prev;
   logic [NW-1:0]         w_sum, w_code_new, w_ld_base;
   logic [MAX_LEN-1:0]    w_ld_code;

   // Input field decode; over-long lengths are stored as unused
   assign w_num     = symbol_i[SYMW-1 -: RLW];
   assign w_rlen    = symbol_i[RLW-1:0];
   assign w_idx     = w_num[DATA_WIDTH-1:0];
   assign w_ovf     = 32'(w_rlen) > MAX_LEN;
   assign w_new_len = w_ovf ? '0 : LW'(w_rlen);
   assign w_old_len = r_vld[w_idx] ? r_len[w_idx] : '0;
   assign w_unused  = ^{w_num[DATA_WIDTH], symbol_i[RLW +: FREQ_WIDTH]};

   // Next_code recurrence for length r_l, plus Kraft check for that length
   assign w_bl_prev  = (r_l == LW'(1)) ? '0 : r_bl[r_l - LW'(1)];
   assign w_sum      = r_code_acc + NW'(w_bl_prev);
   assign w_code_new = NW'({w_sum, 1'b0});
   assign w_kraft    = (SW'(w_code_new) + SW'(r_bl[r_l])) > (SW'(1) << r_l);

   // Next code to present. On entry the MAX_LEN entry is still being written,
   // and after a handshake the just-consumed length is still being bumped,
   // so both cases forward the in-flight value.
   assign w_ld_sym  = w_ld_first ? '0 : r_code_sym + DATA_WIDTH'(1);
   assign w_ld_len  = r_vld[w_ld_sym] ? r_len[w_ld_sym] : '0;
   assign w_ld_base = (w_ld_first && (w_ld_len == LW'(MAX_LEN))) ? w_code_new : r_nc[w_ld_len];
   assign w_ld_bump = !w_ld_first && (w_ld_len == r_code_len);
   assign w_ld_code = (w_ld_len == '0) ? '0 : MAX_LEN'(w_ld_base) + MAX_LEN'(w_ld_bump);
   assign w_ld_first = w_nc_step && (r_l == LW'(MAX_LEN));
   assign w_ld_next  = w_hs && !r_code_last;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (input_start_i) w_state_nxt = input_end_i ? S_NEXTCODE : S_CAPTURE;
         S_CAPTURE:  if (input_end_i) w_state_nxt = S_NEXTCODE;
         S_NEXTCODE: if (r_l == LW'(MAX_LEN)) w_state_nxt = S_ASSIGN;
         S_ASSIGN:   if (code_ready_i && r_code_last) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      w_cap_first = 1'b0;
      w_cap       = 1'b0;
      w_nc_step   = 1'b0;
      w_hs        = 1'b0;
      case (r_state)
         S_IDLE:     w_cap_first = input_start_i;
         S_CAPTURE:  w_cap       = 1'b1;
         S_NEXTCODE: w_nc_step   = 1'b1;
         S_ASSIGN:   w_hs        = code_ready_i;
         default:    ;
      endcase
   end

   // Tables, histogram, next_code and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len        <= '{default: '0};
         r_bl         <= '{default: '0};
         r_nc         <= '{default: '0};
         r_vld        <= '0;
         r_code_acc   <= '0;
         r_l          <= LW'(1);
         r_busy       <= 1'b0;
         r_code_valid <= 1'b0;
         r_code_last  <= 1'b0;
         r_code_sym   <= '0;
         r_code_len   <= '0;
         r_code       <= '0;
         r_err        <= 1'b0;
      end else begin
         r_busy       <= (w_state_nxt != S_IDLE);
         r_code_valid <= (w_state_nxt == S_ASSIGN);

         if (w_cap_first || w_cap) begin
            if (w_cap_first) r_vld <= '0;
            r_vld[w_idx] <= 1'b1;
            r_len[w_idx] <= w_new_len;
            // Net histogram update so a duplicate with equal length cancels out
            for (int unsigned l = 1; l <= MAX_LEN; l++) begin
               if (w_cap_first)
                  r_bl[LW'(l)] <= CW'(w_new_len == LW'(l));
               else
                  r_bl[LW'(l)] <= r_bl[LW'(l)] + CW'(w_new_len == LW'(l))
                                               - CW'(w_old_len == LW'(l));
            end
         end

         if (w_cap_first)    r_err <= w_ovf;
         else if (w_cap)     r_err <= r_err | w_ovf;
         else if (w_nc_step) r_err <= r_err | w_kraft;

         if (w_nc_step) begin
            r_nc[r_l]  <= w_code_new;
            r_code_acc <= w_code_new;
            r_l        <= r_l + LW'(1);
         end else begin
            r_code_acc <= '0;
            r_l        <= LW'(1);
         end

         if (w_hs && (r_code_len != '0))
            r_nc[r_code_len] <= r_nc[r_code_len] + NW'(1);

         if (w_ld_first || w_ld_next) begin
            r_code_sym  <= w_ld_sym;
            r_code_len  <= w_ld_len;
            r_code      <= w_ld_code;
            r_code_last <= &w_ld_sym;
         end else if (w_hs) begin
            r_code_sym  <= '0;
            r_code_len  <= '0;
            r_code      <= '0;
            r_code_last <= 1'b0;
         end
      end
   end

   assign busy_o       = r_busy;
   assign code_valid_o = r_code_valid;
   assign code_sym_o   = r_code_sym;
   assign code_len_o   = r_code_len;
   assign code_o       = r_code;
   assign code_last_o  = r_code_last;
   assign err_o        = r_err;

endmodule
